// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the I/D cacheline memory arbiter
package mem_arb_pkg;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-cache, D-cache and adaptor signals seen by the arbiter
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [ADDR_W-1:0] m_addr;
    logic              m_read;
    logic              m_write;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;
    logic              err_timeout;

    // master is the arbiter itself; slave is everything around it
    modport master (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata,
               err_timeout
    );

    modport slave (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_addr, m_read, m_write, m_wdata,
               err_timeout
    );
endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; ties go to whoever was not served last
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    i_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output logic    valid,
    output req_id_t pick
);
    always_comb begin
        valid = i_req | d_req;
        pick  = REQ_I;
        if (d_req && (!i_req || last_grant == REQ_I)) begin
            pick = REQ_D;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one cacheline memory port between I-cache and D-cache
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_t        state;
    req_id_t           last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              write_q;
    logic [LINE_W-1:0] wdata_q;
    logic [CNT_W-1:0]  wd_cnt;
    logic              err_q;

    logic    pick_valid;
    req_id_t pick;

    rr_pick2 u_pick (
        .i_req      (bus.i_read),
        .d_req      (bus.d_read | bus.d_write),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .pick       (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ_D;
            addr_q     <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            wd_cnt     <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        wd_cnt <= '0;
                        if (pick == REQ_I) begin
                            addr_q  <= bus.i_addr;
                            read_q  <= 1'b1;
                            write_q <= 1'b0;
                            wdata_q <= '0;
                            state   <= GRANT_I;
                        end else begin
                            addr_q  <= bus.d_addr;
                            read_q  <= !bus.d_write;
                            write_q <= bus.d_write;
                            wdata_q <= bus.d_wdata;
                            state   <= GRANT_D;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (bus.m_resp) begin
                        last_grant <= (state == GRANT_I) ? REQ_I : REQ_D;
                        read_q     <= 1'b0;
                        write_q    <= 1'b0;
                        state      <= IDLE;
                    end else if (wd_cnt != CNT_MAX) begin
                        // saturating count; the flag only reports, the transaction keeps waiting
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_cnt == CNT_MAX - 1'b1) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic i_done;
    logic d_done;

    assign i_done = (state == GRANT_I) && bus.m_resp;
    assign d_done = (state == GRANT_D) && bus.m_resp;

    // request lines drop in the completion cycle so the adaptor never sees a stale strobe
    assign bus.m_addr      = addr_q;
    assign bus.m_read      = read_q  && !bus.m_resp;
    assign bus.m_write     = write_q && !bus.m_resp;
    assign bus.m_wdata     = wdata_q;
    assign bus.i_resp      = i_done;
    assign bus.d_resp      = d_done;
    assign bus.i_rdata     = (i_done && read_q) ? bus.m_rdata : '0;
    assign bus.d_rdata     = (d_done && read_q) ? bus.m_rdata : '0;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table plus response scoreboard for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        req_id_t     who;
        logic [31:0] addr;
        logic        wr;
        logic [255:0] wdata;
    } exp_t;

    typedef struct {
        bit           ir;
        logic [31:0]  ia;
        bit           dr;
        bit           dw;
        logic [31:0]  da;
        logic [255:0] wd;
        int           lat;
        req_id_t      first;
    } vec_t;

    exp_t sb[$];
    int   resp_cycs[$];
    int   grant_cycs[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   lat = 2;
    int   busy = 0;
    int   resp_cnt = 0;
    bit   withhold = 0;
    bit   force_resp = 0;
    bit   prev_act = 0;
    logic g_read, g_write;
    logic [31:0] g_addr;

    function automatic logic [255:0] line_of(logic [31:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_i(logic [31:0] a);
        bus.i_addr = a;
        bus.i_read = 1'b1;
        sb.push_back('{REQ_I, a, 1'b0, 256'd0});
    endtask

    task automatic set_d(logic [31:0] a, bit wr, logic [255:0] wd);
        bus.d_addr  = a;
        bus.d_read  = !wr;
        bus.d_write = wr;
        bus.d_wdata = wd;
        sb.push_back('{REQ_D, a, wr, wr ? wd : 256'd0});
    endtask

    task automatic monitor();
        exp_t e;
        req_id_t who;
        if (bus.i_resp || bus.d_resp) begin
            chk("single_resp", 256'(bus.i_resp & bus.d_resp), 256'd0);
            who = bus.i_resp ? REQ_I : REQ_D;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_resp: i_resp=%0b d_resp=%0b with nothing pending",
                         bus.i_resp, bus.d_resp);
            end else begin
                e = sb.pop_front();
                chk("resp_who", 256'(who), 256'(e.who));
                chk("m_addr", 256'(bus.m_addr), 256'(e.addr));
                chk("m_write", 256'(g_write), 256'(e.wr));
                chk("m_wdata", bus.m_wdata, e.wdata);
                if (who == REQ_I) begin
                    chk("i_rdata", bus.i_rdata, line_of(e.addr));
                    chk("d_rdata_quiet", bus.d_rdata, 256'd0);
                end else begin
                    chk("d_rdata", bus.d_rdata, e.wr ? 256'd0 : line_of(e.addr));
                    chk("i_rdata_quiet", bus.i_rdata, 256'd0);
                end
            end
            if (bus.i_resp) bus.i_read = 1'b0;
            if (bus.d_resp) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
            resp_cycs.push_back(cyc);
            resp_cnt++;
        end
    endtask

    // one clock: adaptor model reacts to the request lines, then responses are scored
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        bus.m_resp = 1'b0;
        #1;
        g_read  = bus.m_read;
        g_write = bus.m_write;
        g_addr  = bus.m_addr;
        if ((g_read || g_write) && !prev_act) grant_cycs.push_back(cyc);
        prev_act = g_read || g_write;
        if (force_resp) begin
            bus.m_resp  = 1'b1;
            bus.m_rdata = line_of(32'hDEAD_0000);
        end else if ((g_read || g_write) && !withhold) begin
            busy++;
            if (busy >= lat) begin
                bus.m_resp  = 1'b1;
                bus.m_rdata = g_write ? '1 : line_of(g_addr);
                busy = 0;
            end
        end else if (!(g_read || g_write)) begin
            busy = 0;
        end
        #1;
        monitor();
    endtask

    task automatic drain(int max);
        int n = 0;
        while (sb.size() > 0 && n < max) begin
            cycle();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses still pending, required 0", sb.size());
            sb.delete();
            bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_m_read"},  256'(g_read),  256'd0);
        chk({tag, "_m_write"}, 256'(g_write), 256'd0);
        chk({tag, "_m_addr"},  256'(bus.m_addr), 256'd0);
        chk({tag, "_m_wdata"}, bus.m_wdata, 256'd0);
        chk({tag, "_resp"},    256'({bus.i_resp, bus.d_resp}), 256'd0);
        chk({tag, "_rdata"},   bus.i_rdata | bus.d_rdata, 256'd0);
        chk({tag, "_err"},     256'(bus.err_timeout), 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

    vec_t vt[7];

    initial begin
        int n;
        int ni;
        int nd;
        bit raise_i;
        bit raise_d;
        logic [255:0] b_line;
        logic [255:0] c_line;

        b_line = {8{32'hB0B0_0001}};
        c_line = {4{64'h0123_4567_89AB_CDEF}};
        vt[0] = '{1, 32'h0000_0100, 1, 0, 32'h0000_0200, 256'd0, 2, REQ_I};
        vt[1] = '{1, 32'h0000_1000, 0, 0, 32'h0,         256'd0, 3, REQ_I};
        vt[2] = '{0, 32'h0,         0, 1, 32'h8000_0020, b_line, 4, REQ_D};
        vt[3] = '{1, 32'h0000_3000, 0, 1, 32'h0000_4000, c_line, 2, REQ_I};
        vt[4] = '{0, 32'h0,         1, 0, 32'h0000_5000, 256'd0, 1, REQ_D};
        vt[5] = '{1, 32'h0000_6000, 0, 0, 32'h0,         256'd0, 1, REQ_I};
        vt[6] = '{1, 32'h0000_7000, 1, 0, 32'h0000_7020, 256'd0, 3, REQ_D};

        bus.i_addr = '0; bus.i_read = 0; bus.d_addr = '0; bus.d_read = 0;
        bus.d_write = 0; bus.d_wdata = '0; bus.m_rdata = '0; bus.m_resp = 0;

        repeat (3) cycle();
        chk_reset_outputs("reset");
        rst = 1'b0;
        cycle();

        foreach (vt[i]) begin
            lat = vt[i].lat;
            resp_cycs.delete();
            grant_cycs.delete();
            if (vt[i].first == REQ_I) begin
                if (vt[i].ir) set_i(vt[i].ia);
                if (vt[i].dr || vt[i].dw) set_d(vt[i].da, vt[i].dw, vt[i].wd);
            end else begin
                if (vt[i].dr || vt[i].dw) set_d(vt[i].da, vt[i].dw, vt[i].wd);
                if (vt[i].ir) set_i(vt[i].ia);
            end
            cycle();
            chk("grant_next_cycle", 256'(g_read | g_write), 256'd1);
            chk("grant_addr", 256'(g_addr), 256'(vt[i].first == REQ_I ? vt[i].ia : vt[i].da));
            chk("grant_is_write", 256'(g_write), 256'(vt[i].first == REQ_D && vt[i].dw));
            drain(60);
            if (vt[i].ir && (vt[i].dr || vt[i].dw)) begin
                if (resp_cycs.size() == 2 && grant_cycs.size() == 2)
                    chk("one_idle_gap", 256'(grant_cycs[1] - resp_cycs[0]), 256'd2);
                else
                    chk("tie_grant_count", 256'(grant_cycs.size()), 256'd2);
            end
            cycle();
        end

        force_resp = 1'b1;
        cycle();
        force_resp = 1'b0;
        chk("idle_m_resp_ignored", 256'({bus.i_resp, bus.d_resp}), 256'd0);
        cycle();
        chk("idle_stays_idle", 256'(g_read | g_write), 256'd0);

        lat = 3;
        withhold = 1'b1;
        set_i(32'h0000_9000);
        for (int k = 1; k <= TO + 1; k++) begin
            cycle();
            if (k == TO) chk("err_not_yet", 256'(bus.err_timeout), 256'd0);
        end
        chk("err_after_timeout", 256'(bus.err_timeout), 256'd1);
        chk("grant_still_held", 256'(g_read), 256'd1);
        withhold = 1'b0;
        busy = 0;
        drain(20);
        cycle();
        chk("err_sticky", 256'(bus.err_timeout), 256'd1);

        withhold = 1'b1;
        set_d(32'h0000_A000, 1'b0, 256'd0);
        repeat (3) cycle();
        chk("grant_d_active", 256'(g_read), 256'd1);
        rst = 1'b1;
        sb.delete();
        bus.d_read = 1'b0;
        cycle();
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        withhold = 1'b0;
        cycle();

        lat = 2;
        resp_cycs.delete();
        grant_cycs.delete();
        ni = 1;
        nd = 1;
        raise_i = 0;
        raise_d = 0;
        set_i(32'h0000_C000);
        set_d(32'h0000_D000, 1'b0, 256'd0);
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            cycle();
            n++;
            if (raise_i) begin set_i(32'h0000_C000 + ni * 32'h20); ni++; raise_i = 0; end
            if (raise_d) begin set_d(32'h0000_D000 + nd * 32'h20, 1'b0, 256'd0); nd++; raise_d = 0; end
            if (bus.i_resp && ni < 3) raise_i = 1;
            if (bus.d_resp && nd < 3) raise_d = 1;
        end
        chk("rr_completions", 256'(resp_cycs.size()), 256'd6);
        for (int k = 0; k < 5; k++) begin
            if (k + 1 < grant_cycs.size() && k < resp_cycs.size())
                chk("rr_gap", 256'(grant_cycs[k+1] - resp_cycs[k]), 256'd2);
        end
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
